sdram_mem_tester: RTL and testbench

Host-side traffic generator that sits directly upstream of the SDRAM controller and drives its host interface (wr/rd/addr/data in, data/done/rdPending out). It fills an address range with a 16-bit LFSR pattern, reads the range back, compares every word, and reports pass/fail, error count and first failing address/data. It is the board-level self-test and the stimulus source for controller bring-up.

---
 rtl/sdram_pkg.sv | 25 ++
 rtl/sdram_mem_tester_if.sv | 18 +
 rtl/sdram_lfsr16.sv | 22 ++
 rtl/sdram_mem_tester.sv | 160 ++++++++++++++++
 tb/tb_sdram_mem_tester.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM host-side tester: bus width defaults,
// the LFSR pattern polynomial and the tester FSM encoding.
package sdram_pkg;

  localparam int ADDR_W_DEF = 24;
  localparam int DATA_W_DEF = 16;

  // x^16 + x^14 + x^13 + x^11 + 1 as bit taps 15,13,12,10 of a left-shifting register
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_REQ,
    S_WR_NEXT,
    S_RD_WAIT,
    S_RD_REQ,
    S_RD_NEXT,
    S_FINISH
  } tst_state_e;

  function automatic logic [15:0] lfsr16_next(input logic [15:0] v);
    return {v[14:0], ^(v & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/sdram_mem_tester_if.sv
// Host-side bus between the tester (master) and the SDRAM controller (slave).
interface sdram_mem_tester_if
  import sdram_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic              wr;
  logic              rd;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              done;
  logic              rd_pending;

  modport master (output wr, rd, addr, wdata, input rdata, done, rd_pending);
  modport slave  (input wr, rd, addr, wdata, output rdata, done, rd_pending);
endinterface

// File: rtl/sdram_lfsr16.sv
// 16-bit Fibonacci pattern generator; nxt_o lets the owner register the
// upcoming word in the same cycle it advances.
module sdram_lfsr16
  import sdram_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        load_i,
  input  logic        adv_i,
  output logic [15:0] value_o,
  output logic [15:0] nxt_o
);
  assign nxt_o = lfsr16_next(value_o);

  always_ff @(posedge clk_i) begin
    if (!rst_n_i)    value_o <= SEED;
    else if (load_i) value_o <= SEED;
    else if (adv_i)  value_o <= nxt_o;
  end
endmodule

// File: rtl/sdram_mem_tester.sv
// Fill/readback memory tester: writes an LFSR pattern over [START_ADDR, LAST_ADDR],
// reads it back, and reports pass/fail with first-error capture and a request watchdog.
module sdram_mem_tester
  import sdram_pkg::*;
#(
  parameter int                ADDR_W     = ADDR_W_DEF,
  parameter int                DATA_W     = DATA_W_DEF,
  parameter logic [ADDR_W-1:0] START_ADDR = '0,
  parameter logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(24'h0000FF),
  parameter logic [15:0]       SEED       = 16'hACE1,
  parameter int                TIMEOUT    = 1023
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                start_i,
  sdram_mem_tester_if.master  host,
  output logic                busy_o,
  output logic                pass_o,
  output logic                fail_o,
  output logic                timeout_o,
  output logic [15:0]         err_cnt_o,
  output logic [ADDR_W-1:0]   err_addr_o,
  output logic [DATA_W-1:0]   err_data_o
);
  localparam int WD_W = $clog2(TIMEOUT + 1);

  tst_state_e        state;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              wr, rd;
  logic [WD_W-1:0]   wd_cnt;
  logic [15:0]       lfsr, lfsr_nxt;
  logic              last, wd_hit, lfsr_load, lfsr_adv;

  assign last   = (addr == LAST_ADDR);
  assign wd_hit = (wd_cnt == WD_W'(TIMEOUT - 1));

  // Pattern restarts from SEED for the read pass so it regenerates the written data
  assign lfsr_load = (state == S_IDLE && start_i) || (state == S_WR_NEXT && last);
  assign lfsr_adv  = (state == S_WR_NEXT || state == S_RD_NEXT) && !last;

  sdram_lfsr16 #(.SEED(SEED)) u_lfsr (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .load_i  (lfsr_load),
    .adv_i   (lfsr_adv),
    .value_o (lfsr),
    .nxt_o   (lfsr_nxt)
  );

  assign host.wr    = wr;
  assign host.rd    = rd;
  assign host.addr  = addr;
  assign host.wdata = wdata;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state      <= S_IDLE;
      addr       <= '0;
      wdata      <= '0;
      wr         <= 1'b0;
      rd         <= 1'b0;
      wd_cnt     <= '0;
      busy_o     <= 1'b0;
      pass_o     <= 1'b0;
      fail_o     <= 1'b0;
      timeout_o  <= 1'b0;
      err_cnt_o  <= '0;
      err_addr_o <= '0;
      err_data_o <= '0;
    end else begin
      case (state)
        S_IDLE: if (start_i) begin
          pass_o     <= 1'b0;
          fail_o     <= 1'b0;
          timeout_o  <= 1'b0;
          err_cnt_o  <= '0;
          err_addr_o <= '0;
          err_data_o <= '0;
          addr       <= START_ADDR;
          wdata      <= DATA_W'(SEED);
          wr         <= 1'b1;
          busy_o     <= 1'b1;
          wd_cnt     <= '0;
          state      <= S_WR_REQ;
        end
        S_WR_REQ: begin
          if (host.done) begin
            wr    <= 1'b0;
            state <= S_WR_NEXT;
          end else if (wd_hit) begin
            wr        <= 1'b0;
            timeout_o <= 1'b1;
            fail_o    <= 1'b1;
            busy_o    <= 1'b0;
            state     <= S_IDLE;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        S_WR_NEXT: begin
          if (last) begin
            addr  <= START_ADDR;
            state <= S_RD_WAIT;
          end else begin
            addr   <= addr + 1'b1;
            wdata  <= DATA_W'(lfsr_nxt);
            wr     <= 1'b1;
            wd_cnt <= '0;
            state  <= S_WR_REQ;
          end
        end
        // Hold off reads until the controller has drained posted work
        S_RD_WAIT: if (!host.rd_pending) begin
          rd     <= 1'b1;
          wd_cnt <= '0;
          state  <= S_RD_REQ;
        end
        S_RD_REQ: begin
          if (host.done) begin
            rd    <= 1'b0;
            state <= S_RD_NEXT;
            if (host.rdata != DATA_W'(lfsr)) begin
              if (err_cnt_o == '0) begin
                err_addr_o <= addr;
                err_data_o <= host.rdata;
              end
              if (err_cnt_o != 16'hFFFF) err_cnt_o <= err_cnt_o + 1'b1;
            end
          end else if (wd_hit) begin
            rd        <= 1'b0;
            timeout_o <= 1'b1;
            fail_o    <= 1'b1;
            busy_o    <= 1'b0;
            state     <= S_IDLE;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        S_RD_NEXT: begin
          if (last) begin
            state <= S_FINISH;
          end else begin
            addr   <= addr + 1'b1;
            rd     <= 1'b1;
            wd_cnt <= '0;
            state  <= S_RD_REQ;
          end
        end
        S_FINISH: begin
          pass_o <= (err_cnt_o == '0);
          fail_o <= (err_cnt_o != '0);
          busy_o <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sdram_mem_tester.sv
// Scoreboard bench: an ideal controller model with per-address read corruption,
// expected requests/results queued at start and checked by a separate monitor.
module tb_sdram_mem_tester;
  localparam logic [23:0] START   = 24'h000000;
  localparam logic [23:0] LAST    = 24'h000003;
  localparam logic [15:0] SEED    = 16'hACE1;
  localparam int          TIMEOUT = 50;

  typedef struct {
    bit          is_wr;
    logic [23:0] addr;
    logic [15:0] data;
  } op_t;

  typedef struct {
    logic        pass;
    logic        fail;
    logic        tmo;
    logic [15:0] cnt;
    logic [23:0] eaddr;
    logic [15:0] edata;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        busy, pass, fail, tmo;
  logic [15:0] err_cnt;
  logic [23:0] err_addr;
  logic [15:0] err_data;

  sdram_mem_tester_if #(.ADDR_W(24), .DATA_W(16)) hif ();

  sdram_mem_tester #(
    .ADDR_W(24), .DATA_W(16), .START_ADDR(START), .LAST_ADDR(LAST),
    .SEED(SEED), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .host(hif),
    .busy_o(busy), .pass_o(pass), .fail_o(fail), .timeout_o(tmo),
    .err_cnt_o(err_cnt), .err_addr_o(err_addr), .err_data_o(err_data)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  op_t  exp_ops[$];
  res_t exp_res[$];

  // ---------------- controller model ----------------
  logic [15:0] mem     [0:255];
  logic [15:0] corrupt [0:255];
  int          lat = 3;
  int          cnt;
  int          pend_cnt;
  bit          no_done = 0;
  bit          pend_hold = 0;
  logic        extra_done = 1'b0;
  logic        done_m;
  logic [15:0] rdata_m;

  assign hif.done       = done_m | extra_done;
  assign hif.rdata      = rdata_m;
  assign hif.rd_pending = (pend_cnt != 0);

  always @(posedge clk) begin
    if (!rst_n) begin
      done_m <= 1'b0; cnt <= 0; pend_cnt <= 0; rdata_m <= '0;
    end else begin
      if (pend_cnt != 0) pend_cnt <= pend_cnt - 1;
      if (done_m) begin
        done_m <= 1'b0; cnt <= 0;
      end else if (!(hif.wr || hif.rd)) begin
        cnt <= 0;
      end else if (!no_done) begin
        if (cnt == lat - 1) begin
          done_m <= 1'b1;
          if (hif.wr) begin
            mem[hif.addr[7:0]] <= hif.wdata;
            if (pend_hold && hif.addr == LAST) pend_cnt <= 5;
          end else begin
            rdata_m <= mem[hif.addr[7:0]] ^ corrupt[hif.addr[7:0]];
          end
        end else begin
          cnt <= cnt + 1;
        end
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [15:0] ref_next(input logic [15:0] v);
    logic fb;
    fb = v[15] ^ v[13] ^ v[12] ^ v[10];
    return {v[14:0], fb};
  endfunction

  task automatic push_run(input bit timeout_run);
    logic [15:0] v;
    logic [15:0] pat [0:255];
    logic [15:0] got;
    res_t r;
    v = SEED;
    r = '{pass: 1'b0, fail: 1'b0, tmo: 1'b0, cnt: 16'h0, eaddr: 24'h0, edata: 16'h0};
    if (timeout_run) begin
      exp_ops.push_back('{is_wr: 1'b1, addr: START, data: SEED});
      r.fail = 1'b1; r.tmo = 1'b1;
      exp_res.push_back(r);
      return;
    end
    for (int a = int'(START); a <= int'(LAST); a++) begin
      exp_ops.push_back('{is_wr: 1'b1, addr: 24'(a), data: v});
      pat[a] = v;
      v = ref_next(v);
    end
    for (int a = int'(START); a <= int'(LAST); a++) begin
      exp_ops.push_back('{is_wr: 1'b0, addr: 24'(a), data: 16'h0});
      got = pat[a] ^ corrupt[a];
      if (got != pat[a]) begin
        if (r.cnt == 0) begin r.eaddr = 24'(a); r.edata = got; end
        r.cnt++;
      end
    end
    r.pass = (r.cnt == 0);
    r.fail = (r.cnt != 0);
    exp_res.push_back(r);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic wr_q, rd_q, busy_q, pend_q;
    op_t  o;
    res_t r;
    wr_q = 0; rd_q = 0; busy_q = 0; pend_q = 0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (hif.wr && !wr_q) begin
          if (exp_ops.size() == 0) chk("unexpected_write", 1, 0);
          else begin
            o = exp_ops.pop_front();
            chk("op_is_write", 1, {63'b0, o.is_wr});
            chk("wr_addr", {40'b0, hif.addr}, {40'b0, o.addr});
            chk("wr_data", {48'b0, hif.wdata}, {48'b0, o.data});
          end
        end
        if (hif.rd && !rd_q) begin
          chk("rd_after_quiescent", {63'b0, pend_q}, 0);
          if (exp_ops.size() == 0) chk("unexpected_read", 1, 0);
          else begin
            o = exp_ops.pop_front();
            chk("op_is_read", 0, {63'b0, o.is_wr});
            chk("rd_addr", {40'b0, hif.addr}, {40'b0, o.addr});
          end
        end
        if (!busy && busy_q) begin
          if (exp_res.size() == 0) chk("unexpected_end", 1, 0);
          else begin
            r = exp_res.pop_front();
            chk("pass", {63'b0, pass}, {63'b0, r.pass});
            chk("fail", {63'b0, fail}, {63'b0, r.fail});
            chk("timeout", {63'b0, tmo}, {63'b0, r.tmo});
            chk("err_cnt", {48'b0, err_cnt}, {48'b0, r.cnt});
            chk("err_addr", {40'b0, err_addr}, {40'b0, r.eaddr});
            chk("err_data", {48'b0, err_data}, {48'b0, r.edata});
          end
        end
      end
      wr_q = hif.wr; rd_q = hif.rd; busy_q = busy; pend_q = hif.rd_pending;
    end
  end

  // ---------------- driver ----------------
  task automatic start_run();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("start_busy", {63'b0, busy}, 1);
    chk("start_wr", {63'b0, hif.wr}, 1);
  endtask

  task automatic wait_idle(input int max_cyc);
    int k = 0;
    while (busy && k < max_cyc) begin @(negedge clk); k++; end
    chk("run_end_bound", {63'b0, busy}, 0);
    repeat (2) @(negedge clk);
    chk("ops_drained", 64'(exp_ops.size()), 0);
    chk("res_drained", 64'(exp_res.size()), 0);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_busy"}, {63'b0, busy}, 0);
    chk({tag, "_pass"}, {63'b0, pass}, 0);
    chk({tag, "_fail"}, {63'b0, fail}, 0);
    chk({tag, "_tmo"}, {63'b0, tmo}, 0);
    chk({tag, "_wr_rd"}, {62'b0, hif.wr, hif.rd}, 0);
    chk({tag, "_addr"}, {40'b0, hif.addr}, 0);
    chk({tag, "_wdata"}, {48'b0, hif.wdata}, 0);
    chk({tag, "_errs"}, {err_cnt, err_addr, err_data}, 0);
  endtask

  initial begin
    int k;
    for (int i = 0; i < 256; i++) begin corrupt[i] = '0; mem[i] = '0; end
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // clean run, fixed latency
    push_run(0);
    start_run();
    wait_idle(500);

    // single-bit corruption at address 2, with a start pulse while busy
    corrupt[2] = 16'h0001;
    lat = $urandom_range(1, 4);
    push_run(0);
    start_run();
    repeat (6) @(negedge clk);
    start = 1'b1; @(negedge clk); start = 1'b0;
    wait_idle(500);
    corrupt[2] = '0;

    // done pulsed while idle must not disturb anything
    @(negedge clk); extra_done = 1'b1;
    @(negedge clk); extra_done = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_done_busy", {63'b0, busy}, 0);
    chk("idle_done_req", {62'b0, hif.wr, hif.rd}, 0);
    chk("idle_done_sticky", {62'b0, pass, fail}, 2'b01);

    // randomized corruption patterns and latencies; first one holds rdPending
    for (int r = 0; r < 5; r++) begin
      lat = $urandom_range(1, 4);
      pend_hold = (r == 0);
      for (int a = int'(START); a <= int'(LAST); a++)
        corrupt[a] = ($urandom_range(0, 1) != 0) ? 16'($urandom_range(1, 65535)) : 16'h0;
      push_run(0);
      start_run();
      wait_idle(500);
    end
    pend_hold = 0;
    for (int a = 0; a < 256; a++) corrupt[a] = '0;

    // watchdog: controller never answers
    no_done = 1;
    push_run(1);
    start_run();
    wait_idle(TIMEOUT + 20);
    chk("tmo_wr_low", {63'b0, hif.wr}, 0);
    chk("tmo_flag", {62'b0, tmo, fail}, 2'b11);
    no_done = 0;

    // reset during the read phase, then a clean rerun
    lat = 2;
    push_run(0);
    start_run();
    k = 0;
    while (!hif.rd && k < 200) begin @(negedge clk); k++; end
    chk("rd_phase_reached", {63'b0, hif.rd}, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_vals("midrst");
    exp_ops.delete();
    exp_res.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    push_run(0);
    start_run();
    wait_idle(500);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "global timeout");
  end
endmodule
